// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/WB loop driving register-file
// write enables, ALU controls and the program counter from an 8-bit instruction word.
module cpu_sequencer #(
    parameter int unsigned PC_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [7:0]      instr,
    input  logic            alu_zero,
    output logic [PC_W-1:0] pc,
    output logic            we_a,
    output logic            we_b,
    output logic [1:0]      alu_op,
    output logic            do_alu,
    output logic            do_store,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic [2:0]      state
);

    localparam int unsigned IR_W = 8;
    localparam int unsigned OP_W = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_LDB = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD = 4'h3;
    localparam logic [OP_W-1:0] OP_OR  = 4'h6;
    localparam logic [OP_W-1:0] OP_JMP = 4'h7;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OP_W-1:0] OP_ILO = 4'h9;
    localparam logic [OP_W-1:0] OP_IHI = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    logic [IR_W-1:0] ir, ir_nxt;
    logic            zero_q, zero_nxt;
    logic [2:0]      state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            we_a_nxt, we_b_nxt, do_alu_nxt, do_store_nxt;
    logic            busy_nxt, halted_nxt, illegal_nxt;
    logic [1:0]      alu_op_nxt;
    logic [OP_W-1:0] op_cur, op_nxt;
    logic            in_dp, is_alu, is_ld;

    assign op_cur = ir[IR_W-1:OP_W];

    // State and registered-output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            zero_q   <= 1'b0;
            we_a     <= 1'b0;
            we_b     <= 1'b0;
            alu_op   <= 2'b00;
            do_alu   <= 1'b0;
            do_store <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            ir       <= ir_nxt;
            zero_q   <= zero_nxt;
            we_a     <= we_a_nxt;
            we_b     <= we_b_nxt;
            alu_op   <= alu_op_nxt;
            do_alu   <= do_alu_nxt;
            do_store <= do_store_nxt;
            busy     <= busy_nxt;
            halted   <= halted_nxt;
            illegal  <= illegal_nxt;
        end
    end

    // Next state, and outputs decoded from the state/instruction being entered
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        ir_nxt       = ir;
        zero_nxt     = zero_q;
        illegal_nxt  = illegal;
        we_a_nxt     = 1'b0;
        we_b_nxt     = 1'b0;
        alu_op_nxt   = 2'b00;
        do_alu_nxt   = 1'b0;
        do_store_nxt = 1'b0;
        busy_nxt     = 1'b0;
        halted_nxt   = 1'b0;
        op_nxt       = '0;
        in_dp        = 1'b0;
        is_alu       = 1'b0;
        is_ld        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                ir_nxt    = instr;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                zero_nxt = alu_zero;
                if (op_cur == OP_HLT) begin
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_WB;
                    if (op_cur >= OP_ILO && op_cur <= OP_IHI) illegal_nxt = 1'b1;
                end
            end
            S_WB: begin
                state_nxt = S_FETCH;
                if (op_cur == OP_JMP || (op_cur == OP_JZ && zero_q))
                    pc_nxt = PC_W'(ir[OP_W-1:0]);
                else
                    pc_nxt = pc + PC_W'(1);
            end
            S_HALT: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Datapath controls track the instruction held from DECODE through WB
        op_nxt = ir_nxt[IR_W-1:OP_W];
        in_dp  = (state_nxt == S_DECODE) || (state_nxt == S_EXEC) || (state_nxt == S_WB);
        is_alu = (op_nxt >= OP_ADD) && (op_nxt <= OP_OR);
        is_ld  = (op_nxt == OP_LDA) || (op_nxt == OP_LDB);

        if (in_dp && is_alu) begin
            do_alu_nxt = 1'b1;
            alu_op_nxt = 2'(op_nxt - OP_ADD);
        end
        if (in_dp && is_ld) do_store_nxt = 1'b1;

        if (state_nxt == S_WB) begin
            we_a_nxt = is_alu || (op_nxt == OP_LDA);
            we_b_nxt = (op_nxt == OP_LDB);
        end

        busy_nxt   = in_dp || (state_nxt == S_FETCH);
        halted_nxt = (state_nxt == S_HALT);
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter: PC_W, 4, program counter width; the PC wraps modulo 2^PC_W.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  level; sampled only in IDLE and HALT.
REQ-005 Port: instr  input  8  instruction word at address pc; opcode [7:4], imm [3:0].
REQ-006 Port: alu_zero  input  1  ALU result equals zero, valid during EXEC.
REQ-007 Port: pc  output  PC_W  fetch address, registered.
REQ-008 Port: we_a, we_b  output  1 each  register-file write enables, registered.
REQ-009 Port: alu_op  output  2  ALU operation code, registered.
REQ-010 Port: do_alu, do_store  output  1 each  write-data source select (ALU / immediate), registered.
REQ-011 Port: busy  output  1  high in FETCH, DECODE, EXEC and WB.
REQ-012 Port: halted  output  1  high in HALT.
REQ-013 Port: illegal  output  1  sticky flag, set by an undefined opcode.
REQ-014 Port: state  output  3  encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.

Function
REQ-015 The block SHALL run a 4-cycle instruction loop: FETCH -> DECODE -> EXEC -> WB -> FETCH.
REQ-016 Transitions SHALL be:
- IDLE -> FETCH on start=1.
- HALT -> FETCH on start=1, with pc cleared to 0.
- Otherwise IDLE and HALT hold.
REQ-017 FETCH SHALL latch instr into an internal instruction register; later states decode only that register.
REQ-018 Opcodes SHALL be:
- 0x0 NOP
- 0x1 LDA (A := imm)
- 0x2 LDB (B := imm)
- 0x3 ADD, alu_op=00
- 0x4 SUB, alu_op=01
- 0x5 AND, alu_op=10
- 0x6 OR, alu_op=11
- 0x7 JMP imm
- 0x8 JZ imm
- 0xF HLT
REQ-019 For ADD/SUB/AND/OR, alu_op and do_alu=1 SHALL be valid from DECODE through WB, and we_a SHALL pulse 1 for exactly the WB cycle.
REQ-020 For LDA/LDB, do_store=1 and do_alu=0 SHALL hold from DECODE through WB, and we_a (LDA) or we_b (LDB) SHALL pulse 1 for exactly the WB cycle.
REQ-021 we_a and we_b SHALL never be high simultaneously, and never be high outside WB.
REQ-022 pc SHALL update only on the WB->FETCH edge:
- JMP: pc := imm.
- JZ: pc := imm if alu_zero sampled at EXEC was 1, else pc+1.
- Otherwise: pc+1.
REQ-023 pc+1 SHALL wrap from 2^PC_W-1 to 0.
REQ-024 HLT SHALL go EXEC -> HALT, skipping WB, with no write pulse and pc unchanged.
REQ-025 Opcodes 0x9-0xE SHALL execute as NOP and set illegal in WB; illegal clears only on reset.
REQ-026 When idle (not in an ALU/store instruction), alu_op SHALL be 00 and do_alu, do_store, we_a, we_b SHALL be 0.

Reset
REQ-027 On rst_n=0, at any time including mid-instruction, the block SHALL immediately set:
- state=IDLE, pc=0, instruction register=0x00.
- we_a=0, we_b=0, alu_op=00, do_alu=0, do_store=0, busy=0, halted=0, illegal=0.
REQ-028 A write pulse interrupted by reset SHALL NOT be resumed after release.
REQ-029 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-030 The bench SHALL cover these scenarios:
- Reset then start=1, program {0x15, 0x23, 0x30, 0xF0} -> we_b pulses at cycle 8; we_a pulses at cycles 4 and 12; alu_op=00 at cycle 12; halted=1 with pc=3.
- JMP 0x7A at pc=2 -> the next FETCH shows pc=0xA; no write pulse during the instruction.
- JZ 0x84 with alu_zero=1 at EXEC -> pc=4; same with alu_zero=0 -> pc=3.
- Instruction at pc=15 (NOP) -> next pc=0 (wrap).
- Opcode 0xB -> illegal=1 after WB and stays set over 3 more instructions; no we pulse.
- rst_n pulsed low during WB of LDA -> outputs zero asynchronously; no further we_a pulse until start is reasserted.
